// File: rtl/lc3b_types.sv
// Shared LC-3b types: memory word, byte write mask and the memory responder FSM state.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_mem_array.sv
// 2^ADDR_BITS x 16 word storage with per-byte synchronous write and a registered read port.
module lc3b_mem_array
   import lc3b_types::*;
#(
   parameter int unsigned ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_BITS-1:0] idx,
   input  logic                 wr_en,
   input  lc3b_mem_wmask        wmask,
   input  lc3b_word             wdata,
   input  logic                 rd_en,
   output lc3b_word             rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;

   lc3b_word mem_q [DEPTH];
   lc3b_word rdata_q;
   lc3b_word rdata_d;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wmask[0]) mem_q[idx][7:0]  <= wdata[7:0];
         if (wmask[1]) mem_q[idx][15:8] <= wdata[15:8];
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) rdata_d = mem_q[idx];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) rdata_q <= 16'h0000;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency memory responder for the LC-3b memory port.
// Optional per-op transaction counters enabled by LC3B_MEMRESP_STATS_EN.
module lc3b_mem_responder
   import lc3b_types::*;
#(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned LATENCY   = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mem_read,
   input  logic          mem_write,
   input  lc3b_mem_wmask mem_byte_enable,
   input  lc3b_word      mem_address,
   input  lc3b_word      mem_wdata,
   output logic          mem_resp,
   output lc3b_word      mem_rdata
`ifdef LC3B_MEMRESP_STATS_EN
   ,
   output logic [15:0]   rd_count,
   output logic [15:0]   wr_count
`endif
);

   localparam int unsigned CNT_W = 4;

   lc3b_memresp_state    state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d;
   lc3b_word             wdata_q, wdata_d;
   lc3b_mem_wmask        wmask_q, wmask_d;
   logic                 is_wr_q, is_wr_d;
   logic                 resp_q, resp_d;

   logic                 req_c;
   logic                 enter_resp_c;
   logic [ADDR_BITS-1:0] txn_idx_c;
   lc3b_word             txn_wdata_c;
   lc3b_mem_wmask        txn_wmask_c;
   logic                 txn_wr_c;
   logic                 unused_addr;

   assign req_c       = mem_read | mem_write;
   assign unused_addr = ^mem_address;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      is_wr_d      = is_wr_q;
      resp_d       = 1'b0;
      enter_resp_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_c) begin
               idx_d   = mem_address[ADDR_BITS:1];
               wdata_d = mem_wdata;
               wmask_d = mem_byte_enable;
               is_wr_d = mem_write;
               if (LATENCY == 1) begin
                  state_d      = RESP;
                  resp_d       = 1'b1;
                  enter_resp_c = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d      = RESP;
               resp_d       = 1'b1;
               enter_resp_c = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A one-cycle latency commits straight from the request inputs.
   always_comb begin
      if (state_q == IDLE) begin
         txn_idx_c   = mem_address[ADDR_BITS:1];
         txn_wdata_c = mem_wdata;
         txn_wmask_c = mem_byte_enable;
         txn_wr_c    = mem_write;
      end else begin
         txn_idx_c   = idx_q;
         txn_wdata_c = wdata_q;
         txn_wmask_c = wmask_q;
         txn_wr_c    = is_wr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= 16'h0000;
         wmask_q <= 2'b00;
         is_wr_q <= 1'b0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         is_wr_q <= is_wr_d;
         resp_q  <= resp_d;
      end
   end

   lc3b_mem_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .idx   (txn_idx_c),
      .wr_en (enter_resp_c & txn_wr_c & rst_n),
      .wmask (txn_wmask_c),
      .wdata (txn_wdata_c),
      .rd_en (enter_resp_c & ~txn_wr_c & rst_n),
      .rdata (mem_rdata)
   );

   assign mem_resp = resp_q;

`ifdef LC3B_MEMRESP_STATS_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;

   // Saturating per-op counters, bumped on entry to RESP.
   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (enter_resp_c && !txn_wr_c && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
      if (enter_resp_c &&  txn_wr_c && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_count_q <= 16'h0000;
         wr_count_q <= 16'h0000;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: LATENCY=3 and LATENCY=1 instances side by side.
module tb_lc3b_mem_responder;
   import lc3b_types::*;

   typedef struct {
      string         name;
      logic          rd;
      logic          wr;
      lc3b_mem_wmask be;
      lc3b_word      addr;
      lc3b_word      wd;
      lc3b_word      exp_rdata;
   } vec_t;

   typedef struct {
      string    name;
      lc3b_word rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          rd3, wr3, rd1, wr1;
   lc3b_mem_wmask be3, be1;
   lc3b_word      addr3, wd3, addr1, wd1;
   logic          resp3, resp1;
   lc3b_word      rdata3, rdata1;
`ifdef LC3B_MEMRESP_STATS_EN
   logic [15:0]   rdc3, wrc3, rdc1, wrc1;
`endif

   lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(rd3), .mem_write(wr3),
      .mem_byte_enable(be3), .mem_address(addr3), .mem_wdata(wd3),
      .mem_resp(resp3), .mem_rdata(rdata3)
`ifdef LC3B_MEMRESP_STATS_EN
      , .rd_count(rdc3), .wr_count(wrc3)
`endif
   );

   lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
      .mem_byte_enable(be1), .mem_address(addr1), .mem_wdata(wd1),
      .mem_resp(resp1), .mem_rdata(rdata1)
`ifdef LC3B_MEMRESP_STATS_EN
      , .rd_count(rdc1), .wr_count(wrc1)
`endif
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic rd, input logic wr, input lc3b_mem_wmask be,
                        input lc3b_word a, input lc3b_word wd);
      if (sel == 1) begin
         rd1 = rd; wr1 = wr; be1 = be; addr1 = a; wd1 = wd;
      end else begin
         rd3 = rd; wr3 = wr; be3 = be; addr3 = a; wd3 = wd;
      end
   endtask

   function automatic logic resp_of(input int sel);
      return (sel == 1) ? resp1 : resp3;
   endfunction

   function automatic lc3b_word rdata_of(input int sel);
      return (sel == 1) ? rdata1 : rdata3;
   endfunction

   task automatic pop_chk(input int sel);
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk(e.name, 32'(rdata_of(sel)), 32'(e.rdata));
      end
   endtask

   // Full handshake: hold request until mem_resp, check latency, data and pulse width.
   task automatic txn(input int sel, input vec_t v);
      exp_t e;
      int   n;
      logic got;
      int   lat;
      lat = (sel == 1) ? 1 : 3;
      e.name = v.name; e.rdata = v.exp_rdata;
      sb.push_back(e);
      @(negedge clk);
      drive(sel, v.rd, v.wr, v.be, v.addr, v.wd);
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (resp_of(sel)) got = 1'b1;
      end
      drive(sel, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
      chk({v.name, "_latency"}, 32'(n), 32'(lat));
      pop_chk(sel);
      @(negedge clk);
      chk({v.name, "_pulse_width"}, 32'(resp_of(sel)), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   n;
      logic seen;
      logic [3:0] pattern;
      int   pulses;
      exp_t e;
      vec_t v;

      vecs[0]  = '{"wr_beef",      0, 1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000};
      vecs[1]  = '{"rd_beef",      1, 0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF};
      vecs[2]  = '{"wr_lo_byte",   0, 1, 2'b01, 16'h0010, 16'h1234, 16'hBEEF};
      vecs[3]  = '{"rd_be34",      1, 0, 2'b00, 16'h0010, 16'h0000, 16'hBE34};
      vecs[4]  = '{"wr_hi_byte",   0, 1, 2'b10, 16'h0010, 16'h5600, 16'hBE34};
      vecs[5]  = '{"rd_5634",      1, 0, 2'b00, 16'h0010, 16'h0000, 16'h5634};
      vecs[6]  = '{"wr_odd_addr",  0, 1, 2'b11, 16'h0021, 16'hA5A5, 16'h5634};
      vecs[7]  = '{"rd_alias",     1, 0, 2'b00, 16'h0220, 16'h0000, 16'hA5A5};
      vecs[8]  = '{"rdwr_is_wr",   1, 1, 2'b11, 16'h0004, 16'h0F0F, 16'hA5A5};
      vecs[9]  = '{"rd_0f0f",      1, 0, 2'b00, 16'h0004, 16'h0000, 16'h0F0F};
      vecs[10] = '{"wr_0001",      0, 1, 2'b11, 16'h0008, 16'h0001, 16'h0F0F};
      vecs[11] = '{"wr_mask_zero", 0, 1, 2'b00, 16'h0008, 16'hFFFF, 16'h0F0F};
      vecs[12] = '{"rd_0001",      1, 0, 2'b00, 16'h0008, 16'h0000, 16'h0001};

      rst_n = 1'b0;
      drive(3, 0, 0, 2'b00, 16'h0000, 16'h0000);
      drive(1, 0, 0, 2'b00, 16'h0000, 16'h0000);
      repeat (3) @(negedge clk);
      chk("reset_resp3",  32'(resp3),  32'd0);
      chk("reset_rdata3", 32'(rdata3), 32'd0);
      chk("reset_resp1",  32'(resp1),  32'd0);
      chk("reset_rdata1", 32'(rdata1), 32'd0);
`ifdef LC3B_MEMRESP_STATS_EN
      chk("reset_rd_count", 32'(rdc3), 32'd0);
      chk("reset_wr_count", 32'(wrc3), 32'd0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) txn(3, vecs[i]);

      // Initiator drops the write after the sample edge; it must still complete.
      e.name = "drop_wr"; e.rdata = 16'h0001;
      sb.push_back(e);
      @(negedge clk);
      drive(3, 0, 1, 2'b11, 16'h0030, 16'h1111);
      @(negedge clk);
      drive(3, 0, 0, 2'b00, 16'h0000, 16'h0000);
      n = 1; seen = resp3;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         seen = resp3;
      end
      chk("drop_wr_latency", 32'(n), 32'd3);
      pop_chk(3);
      v = '{"rd_1111", 1, 0, 2'b00, 16'h0030, 16'h0000, 16'h1111};
      txn(3, v);

      // Reset while BUSY aborts the write.
      @(negedge clk);
      drive(3, 0, 1, 2'b11, 16'h0008, 16'h7777);
      @(negedge clk);
      rst_n = 1'b0;
      drive(3, 0, 0, 2'b00, 16'h0000, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (resp3) seen = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_resp", 32'(seen), 32'd0);
      chk("abort_rdata",   32'(rdata3), 32'd0);
      v = '{"rd_after_abort", 1, 0, 2'b00, 16'h0008, 16'h0000, 16'h0001};
      txn(3, v);

      // Reset on the request's sample edge wins.
      @(negedge clk);
      rst_n = 1'b0;
      drive(3, 1, 0, 2'b00, 16'h0008, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      drive(3, 0, 0, 2'b00, 16'h0000, 16'h0000);
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (resp3) seen = 1'b1;
      end
      chk("reset_beats_req", 32'(seen), 32'd0);
`ifdef LC3B_MEMRESP_STATS_EN
      chk("lat3_rd_count", 32'(rdc3), 32'd0);
`endif

      // LATENCY=1: preload then back-to-back reads with request held.
      v = '{"l1_wr_0000", 0, 1, 2'b11, 16'h0000, 16'hAAAA, 16'h0000};
      txn(1, v);
      v = '{"l1_wr_0002", 0, 1, 2'b11, 16'h0002, 16'h5555, 16'h0000};
      txn(1, v);
      e.name = "l1_rd_0000"; e.rdata = 16'hAAAA; sb.push_back(e);
      e.name = "l1_rd_0002"; e.rdata = 16'h5555; sb.push_back(e);
      @(negedge clk);
      drive(1, 1, 0, 2'b00, 16'h0000, 16'h0000);
      pattern = 4'b0000; pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         pattern[c] = resp1;
         if (resp1) begin
            pulses++;
            pop_chk(1);
         end
         if (c == 0) drive(1, 1, 0, 2'b00, 16'h0002, 16'h0000);
         if (c == 2) drive(1, 0, 0, 2'b00, 16'h0000, 16'h0000);
      end
      chk("l1_resp_pattern", 32'(pattern), 32'h5);
      chk("l1_pulse_count",  32'(pulses),  32'd2);
`ifdef LC3B_MEMRESP_STATS_EN
      chk("l1_rd_count", 32'(rdc1), 32'd2);
      chk("l1_wr_count", 32'(wrc1), 32'd2);
`endif
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
